// File: rtl/arbitro_uart_tx_if.sv
// Bus between the two sending control units, the arbiter and uart_tx.
// Byte handshake: iniciar_x is a 1-cycle strobe with dado_x, honoured only while concedido_x is high; acabou_x answers with a 1-cycle pulse.
interface arbitro_uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  req_a;
    logic                  iniciar_a;
    logic [DATA_WIDTH-1:0] dado_a;
    logic                  concedido_a;
    logic                  acabou_a;
    logic                  req_b;
    logic                  iniciar_b;
    logic [DATA_WIDTH-1:0] dado_b;
    logic                  concedido_b;
    logic                  acabou_b;
    logic [DATA_WIDTH-1:0] uart_dado;
    logic                  uart_partida;
    logic                  uart_pronto;
    logic                  erro_timeout;
    logic [2:0]            db_estado;

    modport slave (
        input  req_a, iniciar_a, dado_a, req_b, iniciar_b, dado_b, uart_pronto,
        output concedido_a, acabou_a, concedido_b, acabou_b,
               uart_dado, uart_partida, erro_timeout, db_estado
    );

    modport master (
        output req_a, iniciar_a, dado_a, req_b, iniciar_b, dado_b, uart_pronto,
        input  concedido_a, acabou_a, concedido_b, acabou_b,
               uart_dado, uart_partida, erro_timeout, db_estado
    );
endinterface

// File: rtl/arbitro_uart_tx.sv
// Round-robin, frame-granular arbiter sharing one uart_tx between requesters A and B.
// Optional busy watchdog enabled by defining ARB_UART_TIMEOUT_EN.
module arbitro_uart_tx #(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 5208
) (
    input  logic              clock,
    input  logic              reset,
    arbitro_uart_tx_if.slave  bus
);
    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        CONCEDE_A = 3'd1,
        OCUPADO_A = 3'd2,
        CONCEDE_B = 3'd3,
        OCUPADO_B = 3'd4
    } estado_t;

    // The watchdog counter is 16 bits wide, so the limit must fit in it.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536 || DATA_WIDTH < 1) begin : g_param_check
        $error("arbitro_uart_tx: parameter out of range");
    end

    estado_t estado;
    logic    ultimo_b;

`ifdef ARB_UART_TIMEOUT_EN
    localparam logic [15:0] LIMITE = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] cnt;
`endif

    assign bus.db_estado = estado;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado           <= OCIOSO;
            ultimo_b         <= 1'b1;
            bus.concedido_a  <= 1'b0;
            bus.concedido_b  <= 1'b0;
            bus.acabou_a     <= 1'b0;
            bus.acabou_b     <= 1'b0;
            bus.uart_partida <= 1'b0;
            bus.uart_dado    <= '0;
            bus.erro_timeout <= 1'b0;
`ifdef ARB_UART_TIMEOUT_EN
            cnt              <= '0;
`endif
        end else begin
            bus.uart_partida <= 1'b0;
            bus.acabou_a     <= 1'b0;
            bus.acabou_b     <= 1'b0;
            case (estado)
                OCIOSO: begin
                    // On a tie, A wins only if B was the last winner.
                    if (bus.req_a && (!bus.req_b || ultimo_b)) begin
                        estado          <= CONCEDE_A;
                        bus.concedido_a <= 1'b1;
                        ultimo_b        <= 1'b0;
                    end else if (bus.req_b) begin
                        estado          <= CONCEDE_B;
                        bus.concedido_b <= 1'b1;
                        ultimo_b        <= 1'b1;
                    end
                end
                CONCEDE_A: begin
                    if (!bus.req_a) begin
                        estado          <= OCIOSO;
                        bus.concedido_a <= 1'b0;
                    end else if (bus.iniciar_a) begin
                        estado           <= OCUPADO_A;
                        bus.uart_dado    <= bus.dado_a;
                        bus.uart_partida <= 1'b1;
`ifdef ARB_UART_TIMEOUT_EN
                        cnt              <= '0;
`endif
                    end
                end
                OCUPADO_A: begin
                    if (bus.uart_pronto) begin
                        estado       <= CONCEDE_A;
                        bus.acabou_a <= 1'b1;
                    end
`ifdef ARB_UART_TIMEOUT_EN
                    else if (cnt == LIMITE) begin
                        estado           <= CONCEDE_A;
                        bus.acabou_a     <= 1'b1;
                        bus.erro_timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
`endif
                end
                CONCEDE_B: begin
                    if (!bus.req_b) begin
                        estado          <= OCIOSO;
                        bus.concedido_b <= 1'b0;
                    end else if (bus.iniciar_b) begin
                        estado           <= OCUPADO_B;
                        bus.uart_dado    <= bus.dado_b;
                        bus.uart_partida <= 1'b1;
`ifdef ARB_UART_TIMEOUT_EN
                        cnt              <= '0;
`endif
                    end
                end
                OCUPADO_B: begin
                    if (bus.uart_pronto) begin
                        estado       <= CONCEDE_B;
                        bus.acabou_b <= 1'b1;
                    end
`ifdef ARB_UART_TIMEOUT_EN
                    else if (cnt == LIMITE) begin
                        estado           <= CONCEDE_B;
                        bus.acabou_b     <= 1'b1;
                        bus.erro_timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
`endif
                end
                default: begin
                    estado          <= OCIOSO;
                    bus.concedido_a <= 1'b0;
                    bus.concedido_b <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_arbitro_uart_tx.sv
// Directed bench for arbitro_uart_tx: grants, byte forwarding, round-robin, isolation, release, reset, timeout.
module tb_arbitro_uart_tx;
    logic clock;
    logic reset;
    int   total;
    int   bad;

    arbitro_uart_tx_if #(.DATA_WIDTH(8)) bus ();

    arbitro_uart_tx #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.req_a = 0; bus.iniciar_a = 0; bus.dado_a = '0;
        bus.req_b = 0; bus.iniciar_b = 0; bus.dado_b = '0;
        bus.uart_pronto = 0;
    endtask

    task automatic pulse_reset();
        reset = 1;
        tick();
        reset = 0;
        tick();
    endtask

    // Sends one byte on the granted side; pronto arrives after lat cycles.
    task automatic do_byte(input bit side_b, input logic [7:0] d, input int lat, input string tag);
        if (side_b) begin bus.iniciar_b = 1; bus.dado_b = d; end
        else        begin bus.iniciar_a = 1; bus.dado_a = d; end
        tick();
        bus.iniciar_a = 0; bus.iniciar_b = 0;
        chk({tag, "_partida"}, bus.uart_partida, 1);
        chk({tag, "_dado"}, bus.uart_dado, d);
        chk({tag, "_estado"}, bus.db_estado, side_b ? 3'd4 : 3'd2);
        tick();
        chk({tag, "_partida_1cyc"}, bus.uart_partida, 0);
        repeat (lat - 1) tick();
        bus.uart_pronto = 1;
        tick();
        bus.uart_pronto = 0;
        chk({tag, "_acabou"}, side_b ? bus.acabou_b : bus.acabou_a, 1);
        chk({tag, "_estado_back"}, bus.db_estado, side_b ? 3'd3 : 3'd1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle_inputs();
        reset = 1;
        tick();

        // 1. reset values
        chk("rst_estado", bus.db_estado, 0);
        chk("rst_conc_a", bus.concedido_a, 0);
        chk("rst_conc_b", bus.concedido_b, 0);
        chk("rst_dado", bus.uart_dado, 0);
        chk("rst_partida", bus.uart_partida, 0);
        chk("rst_erro", bus.erro_timeout, 0);
        reset = 0;
        tick();
        chk("idle_estado", bus.db_estado, 0);

        // 2. single A frame
        bus.req_a = 1;
        tick();
        chk("a_conc", bus.concedido_a, 1);
        chk("a_conc_b", bus.concedido_b, 0);
        chk("a_estado", bus.db_estado, 1);
        bus.iniciar_a = 1; bus.dado_a = 8'hA5;
        tick();
        bus.iniciar_a = 0;
        chk("a5_partida", bus.uart_partida, 1);
        chk("a5_dado", bus.uart_dado, 8'hA5);
        // iniciar while busy is ignored
        bus.iniciar_a = 1; bus.dado_a = 8'hFF;
        tick();
        bus.iniciar_a = 0;
        chk("busy_ini_partida", bus.uart_partida, 0);
        chk("busy_ini_dado", bus.uart_dado, 8'hA5);
        repeat (18) tick();
        chk("a5_no_acabou", bus.acabou_a, 0);
        bus.uart_pronto = 1;
        tick();
        bus.uart_pronto = 0;
        chk("a5_acabou", bus.acabou_a, 1);
        do_byte(0, 8'h11, 2, "b2b1");
        do_byte(0, 8'h22, 5, "b2b2");
        tick();
        chk("acabou_1cyc", bus.acabou_a, 0);
        bus.req_a = 0;
        tick();
        chk("rel_conc_a", bus.concedido_a, 0);
        chk("rel_estado", bus.db_estado, 0);

        // 3/4. tie from reset, isolation, round-robin
        pulse_reset();
        bus.req_a = 1; bus.req_b = 1;
        tick();
        chk("tie1_conc_a", bus.concedido_a, 1);
        chk("tie1_conc_b", bus.concedido_b, 0);
        bus.uart_pronto = 1;
        tick();
        bus.uart_pronto = 0;
        chk("spur_pronto_acabou", bus.acabou_a, 0);
        chk("spur_pronto_estado", bus.db_estado, 1);
        do_byte(0, 8'h5A, 3, "tie_a");
        bus.iniciar_b = 1; bus.dado_b = 8'h3C;
        tick();
        bus.iniciar_b = 0;
        chk("iso_partida", bus.uart_partida, 0);
        chk("iso_dado", bus.uart_dado, 8'h5A);
        chk("iso_estado", bus.db_estado, 1);
        tick();
        chk("iso_acabou_b", bus.acabou_b, 0);
        bus.req_a = 0;
        tick();
        chk("a_rel_estado", bus.db_estado, 0);
        tick();
        chk("b_conc", bus.concedido_b, 1);
        chk("b_conc_a", bus.concedido_a, 0);
        chk("b_estado", bus.db_estado, 3);
        do_byte(1, 8'hC3, 4, "b_byte");
        bus.req_b = 0;
        tick();
        chk("b_rel_estado", bus.db_estado, 0);
        bus.req_a = 1; bus.req_b = 1;
        tick();
        chk("tie2_conc_a", bus.concedido_a, 1);
        chk("tie2_conc_b", bus.concedido_b, 0);
        bus.req_a = 0; bus.req_b = 0;
        tick();
        chk("tie2_rel", bus.db_estado, 0);

        // 5. release mid-byte
        bus.req_a = 1;
        tick();
        bus.iniciar_a = 1; bus.dado_a = 8'h77;
        tick();
        bus.iniciar_a = 0;
        bus.req_a = 0;
        tick();
        chk("mid_conc", bus.concedido_a, 1);
        chk("mid_estado", bus.db_estado, 2);
        repeat (3) tick();
        bus.uart_pronto = 1;
        tick();
        bus.uart_pronto = 0;
        chk("mid_acabou", bus.acabou_a, 1);
        chk("mid_conc_held", bus.concedido_a, 1);
        tick();
        chk("mid_rel_estado", bus.db_estado, 0);
        chk("mid_rel_conc", bus.concedido_a, 0);

        // 1. reset mid-byte
        bus.req_a = 1;
        tick();
        bus.iniciar_a = 1; bus.dado_a = 8'h96;
        tick();
        bus.iniciar_a = 0;
        chk("pre_rst_estado", bus.db_estado, 2);
        reset = 1;
        #1;
        chk("async_rst_estado", bus.db_estado, 0);
        chk("async_rst_conc", bus.concedido_a, 0);
        chk("async_rst_dado", bus.uart_dado, 0);
        chk("async_rst_partida", bus.uart_partida, 0);
        bus.req_a = 0;
        tick();
        reset = 0;
        bus.uart_pronto = 1;
        tick();
        bus.uart_pronto = 0;
        chk("post_rst_acabou", bus.acabou_a, 0);
        chk("post_rst_partida", bus.uart_partida, 0);
        chk("post_rst_estado", bus.db_estado, 0);

        // 6. no pronto after a start
        bus.req_a = 1;
        tick();
        bus.iniciar_a = 1; bus.dado_a = 8'h42;
        tick();
        bus.iniciar_a = 0;
`ifdef ARB_UART_TIMEOUT_EN
        repeat (15) tick();
        chk("to_pre_acabou", bus.acabou_a, 0);
        chk("to_pre_erro", bus.erro_timeout, 0);
        tick();
        chk("to_acabou", bus.acabou_a, 1);
        chk("to_erro", bus.erro_timeout, 1);
        chk("to_estado", bus.db_estado, 1);
        tick();
        chk("to_sticky", bus.erro_timeout, 1);
`else
        repeat (100) tick();
        chk("nto_estado", bus.db_estado, 2);
        chk("nto_erro", bus.erro_timeout, 0);
        chk("nto_acabou", bus.acabou_a, 0);
        bus.uart_pronto = 1;
        tick();
        bus.uart_pronto = 0;
        chk("nto_done", bus.acabou_a, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
